// File: rtl/ides_bitslip_if.sv
// Serial-in / word-out bundle for the bit-slip deserializer.
// The master drives the serial data and slip request; the slave returns the aligned words.
interface ides_bitslip_if #(
    parameter int WIDTH = 4
);
    logic             d;
    logic             calib;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             busy;

    modport master (output d, output calib, input q, input q_vld, input busy);
    modport slave  (input d, input calib, output q, output q_vld, output busy);
endinterface

// File: rtl/ides_bitslip.sv
// Single-clock 1:WIDTH deserializer with bit-slip alignment.
// It stands in for the Gowin dual-clock IDES primitives in simulation.
module ides_bitslip #(
    parameter int               WIDTH     = 4,
    parameter bit               LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] INIT      = '0
) (
    input logic           clk_i,
    input logic           rst_i,
    ides_bitslip_if.slave bus
);
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int LOCK_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(WIDTH);

    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [LOCK_W-1:0] lock_q;
    logic [WIDTH-1:0]  q_q;
    logic              q_vld_q;
    logic              calib_q;
    logic              slip;

    // The oldest bit of the window always ends up at the end that becomes the first word bit.
    always_comb begin
        sr_d = sr_q;
        if (LSB_FIRST) begin
            sr_d = {bus.d, sr_q[WIDTH-1:1]};
        end else begin
            sr_d = {sr_q[WIDTH-2:0], bus.d};
        end
    end

    assign slip = bus.calib & ~calib_q & (lock_q == '0);

    // calib_q resets high so a CALIB level held through reset is not seen as an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= INIT;
            q_vld_q <= 1'b0;
            lock_q  <= '0;
            calib_q <= 1'b1;
        end else begin
            sr_q    <= sr_d;
            calib_q <= bus.calib;
            q_vld_q <= 1'b0;
            if (lock_q != '0) begin
                lock_q <= lock_q - LOCK_W'(1);
            end
            if (slip) begin
                lock_q <= LOCK_LOAD;
            end else if (cnt_q == CNT_LAST) begin
                q_q     <= sr_d;
                q_vld_q <= 1'b1;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.q     = q_q;
    assign bus.q_vld = q_vld_q;
    assign bus.busy  = (lock_q != '0);
endmodule

// File: tb/tb_ides_bitslip.sv
// Directed plus randomized bench for ides_bitslip; an LSB-first and an MSB-first
// instance see identical stimulus and are checked against a word-window model.
module tb_ides_bitslip;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compares = 0;
    int   fails = 0;
    int   vldSeen = 0;
    int   busySeen = 0;

    ides_bitslip_if #(.WIDTH(W)) ifL ();
    ides_bitslip_if #(.WIDTH(W)) ifM ();

    ides_bitslip #(.WIDTH(W), .LSB_FIRST(1'b1), .INIT('0)) dutL (.clk_i(clk), .rst_i(rst), .bus(ifL));
    ides_bitslip #(.WIDTH(W), .LSB_FIRST(1'b0), .INIT('0)) dutM (.clk_i(clk), .rst_i(rst), .bus(ifM));

    always #5 clk = ~clk;

    // Model: bit index since reset, index that completes the next word, last slip index.
    int         mk = -1;
    int         nextEmit = W - 1;
    int         lastSlip = -100;
    bit         prevCalib = 1'b1;
    bit         win[$];
    logic [W-1:0] expQL = '0, expQM = '0;
    logic       expVld = 1'b0, expBusy = 1'b0;

    task automatic modelStep(input bit d, input bit calib, input bit r);
        bit slipNow;
        if (r) begin
            mk = -1; nextEmit = W - 1; lastSlip = -100; prevCalib = 1'b1;
            win.delete();
            expQL = '0; expQM = '0; expVld = 1'b0; expBusy = 1'b0;
        end else begin
            mk++;
            win.push_back(d);
            if (win.size() > W) void'(win.pop_front());
            slipNow = calib && !prevCalib && (mk - lastSlip >= W + 1);
            prevCalib = calib;
            expVld = 1'b0;
            if (slipNow) begin
                lastSlip = mk;
                nextEmit++;
            end else if (mk == nextEmit) begin
                for (int i = 0; i < W; i++) begin
                    expQL[i] = win[i];
                    expQM[W-1-i] = win[i];
                end
                expVld = 1'b1;
                nextEmit = mk + W;
            end
            expBusy = (mk - lastSlip) < W;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit d, input bit calib, input bit r);
        ifL.d = d; ifM.d = d; ifL.calib = calib; ifM.calib = calib; rst = r;
        @(posedge clk);
        modelStep(d, calib, r);
        #1;
        if (ifL.q_vld === 1'b1) vldSeen++;
        if (ifL.busy === 1'b1) busySeen++;
        checkOutput("qLsb", 16'(ifL.q), 16'(expQL));
        checkOutput("qMsb", 16'(ifM.q), 16'(expQM));
        checkOutput("vldLsb", 16'(ifL.q_vld), 16'(expVld));
        checkOutput("vldMsb", 16'(ifM.q_vld), 16'(expVld));
        checkOutput("busyLsb", 16'(ifL.busy), 16'(expBusy));
        checkOutput("busyMsb", 16'(ifM.busy), 16'(expBusy));
    endtask

    initial begin
        logic [3:0] slipQ [4];
        logic [3:0] pat;
        int guard;
        slipQ[0] = 4'h8; slipQ[1] = 4'h4; slipQ[2] = 4'h2; slipQ[3] = 4'h1;
        ifL.d = 1'b0; ifM.d = 1'b0; ifL.calib = 1'b0; ifM.calib = 1'b0;

        $display("[TB] reset with random data");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 1'b0, 1'b1);
            checkOutput("resetQ", 16'(ifL.q), 16'h0);
            checkOutput("resetVld", 16'(ifL.q_vld), 16'h0);
        end

        $display("[TB] framing 1,0,1,1");
        pat = 4'b1101;
        vldSeen = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(pat[i%4], 1'b0, 1'b0);
            if (i == 3) checkOutput("firstVld", 16'(ifL.q_vld), 16'h1);
            if (i == 2) checkOutput("noEarlyVld", 16'(ifL.q_vld), 16'h0);
        end
        checkOutput("vldCount", 16'(vldSeen), 16'd4);
        checkOutput("frameLsb", 16'(ifL.q), 16'hD);
        checkOutput("frameMsb", 16'(ifM.q), 16'hB);

        $display("[TB] bit slip on 1,0,0,0");
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(i % 4 == 0, 1'b0, 1'b0);
        checkOutput("slip0", 16'(ifL.q), 16'h1);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(mk % 4 == 3, 1'b1, 1'b0);
            for (int i = 0; i < 11; i++) applyStimulus(mk % 4 == 3, 1'b0, 1'b0);
            checkOutput("slipQ", 16'(ifL.q), 16'(slipQ[s]));
        end

        $display("[TB] CALIB held high");
        busySeen = 0;
        for (int i = 0; i < 20; i++) applyStimulus(1'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'($urandom), 1'b0, 1'b0);
        checkOutput("heldBusy", 16'(busySeen), 16'd4);

        $display("[TB] CALIB edges two cycles apart");
        busySeen = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1'($urandom), i % 2 == 0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'($urandom), 1'b0, 1'b0);
        checkOutput("closeBusy", 16'(busySeen), 16'd4);

        $display("[TB] slip on last bit of word");
        guard = 0;
        while (!((mk + 1 == nextEmit) && (mk + 1 - lastSlip >= W + 1)) && guard < 20) begin
            applyStimulus(1'($urandom), 1'b0, 1'b0);
            guard++;
        end
        checkOutput("alignGuard", 16'(guard < 20), 16'h1);
        applyStimulus(1'($urandom), 1'b1, 1'b0);
        checkOutput("suppressed", 16'(ifL.q_vld), 16'h0);
        applyStimulus(1'($urandom), 1'b0, 1'b0);
        checkOutput("delayed", 16'(ifL.q_vld), 16'h1);

        $display("[TB] reset mid-word with CALIB held");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        busySeen = 0;
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(pat[i], 1'b1, 1'b0);
            if (i < 3) checkOutput("initHold", 16'(ifL.q), 16'h0);
        end
        checkOutput("rstNoSlip", 16'(busySeen), 16'd0);
        checkOutput("rstWordVld", 16'(ifL.q_vld), 16'h1);
        checkOutput("rstWordLsb", 16'(ifL.q), 16'hB);
        checkOutput("rstWordMsb", 16'(ifM.q), 16'hD);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
